// File: rtl/param_shift_reg_pkg.sv
// Package for param_shift_reg: operation-select encoding shared by the
// top level and the next-state logic.
package param_shift_reg_pkg;

    localparam int MODE_W = 3;

    // Operation codes carried on the Mode input
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

endpackage : param_shift_reg_pkg

// File: rtl/param_shift_reg_next.sv
// Next-state logic for param_shift_reg: computes the next stage contents and
// the next fill count from the current registered state and the inputs.
// Optional build macro: PARAM_SHIFT_REG_ASSERT_EN compiles in immediate
// assertions that sanity-check the computed next state.
module param_shift_reg_next
    import param_shift_reg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH*WIDTH-1:0] cur_stages,
    input  logic [FILL_W-1:0]      cur_fill,
    input  logic                   en,
    input  logic [MODE_W-1:0]      mode,
    input  logic [WIDTH-1:0]       din,
    input  logic [DEPTH*WIDTH-1:0] pin,
    output logic [DEPTH*WIDTH-1:0] next_stages,
    output logic [FILL_W-1:0]      next_fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    // Shifting fills one more stage until every stage holds real data
    logic [FILL_W-1:0] fill_inc_s;

    // Saturating increment of the fill count
    always_comb begin
        if (cur_fill < FILL_MAX) begin
            fill_inc_s = cur_fill + FILL_W'(1);
        end else begin
            fill_inc_s = FILL_MAX;
        end
    end

    // Select the operation; stage 0 is the SHL entry end, stage DEPTH-1 the SHR entry end
    always_comb begin
        next_stages = cur_stages;
        next_fill   = cur_fill;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: begin
                    next_stages = cur_stages;
                end
                MODE_SHL: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        next_stages[i*WIDTH +: WIDTH] = cur_stages[(i-1)*WIDTH +: WIDTH];
                    end
                    next_stages[0 +: WIDTH] = din;
                    next_fill = fill_inc_s;
                end
                MODE_SHR: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        next_stages[i*WIDTH +: WIDTH] = cur_stages[(i+1)*WIDTH +: WIDTH];
                    end
                    next_stages[(DEPTH-1)*WIDTH +: WIDTH] = din;
                    next_fill = fill_inc_s;
                end
                MODE_LOAD: begin
                    next_stages = pin;
                    next_fill   = FILL_MAX;
                end
                MODE_ROTL: begin
                    // With a single stage the wrap-around is the stage itself
                    for (int i = 1; i < DEPTH; i++) begin
                        next_stages[i*WIDTH +: WIDTH] = cur_stages[(i-1)*WIDTH +: WIDTH];
                    end
                    next_stages[0 +: WIDTH] = cur_stages[(DEPTH-1)*WIDTH +: WIDTH];
                end
                MODE_ROTR: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        next_stages[i*WIDTH +: WIDTH] = cur_stages[(i+1)*WIDTH +: WIDTH];
                    end
                    next_stages[(DEPTH-1)*WIDTH +: WIDTH] = cur_stages[0 +: WIDTH];
                end
                MODE_CLEAR: begin
                    next_stages = '0;
                    next_fill   = '0;
                end
                default: begin
                    // Reserved code: hold
                    next_stages = cur_stages;
                    next_fill   = cur_fill;
                end
            endcase
        end else begin
            next_stages = cur_stages;
            next_fill   = cur_fill;
        end

`ifdef PARAM_SHIFT_REG_ASSERT_EN
        a_hold_when_idle: assert (en || ((next_stages == cur_stages) && (next_fill == cur_fill)));
        a_shl_takes_din:  assert (!(en && (mode == MODE_SHL)) || (next_stages[0 +: WIDTH] == din));
        a_load_takes_pin: assert (!(en && (mode == MODE_LOAD)) || (next_stages == pin));
        a_fill_in_range:  assert (cur_fill <= FILL_MAX);
`endif
    end

endmodule : param_shift_reg_next

// File: rtl/param_shift_reg.sv
// param_shift_reg: DEPTH x WIDTH shift register with shift, rotate, parallel
// load and clear, plus a saturating count of stages holding data.
// Optional build macro: PARAM_SHIFT_REG_ASSERT_EN (assertions in next-state logic).
module param_shift_reg
    import param_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         En,
    input  logic [MODE_W-1:0]            Mode,
    input  logic [WIDTH-1:0]             Din,
    input  logic [DEPTH*WIDTH-1:0]       Pin,
    output logic [WIDTH-1:0]             Dout,
    output logic [DEPTH*WIDTH-1:0]       Pout,
    output logic [$clog2(DEPTH+1)-1:0]   Fill,
    output logic                         Full
);

    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [DEPTH*WIDTH-1:0] stage_r;
    logic [FILL_W-1:0]      fill_r;
    logic [DEPTH*WIDTH-1:0] next_stages_s;
    logic [FILL_W-1:0]      next_fill_s;

    param_shift_reg_next #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FILL_W (FILL_W)
    ) u_next (
        .cur_stages  (stage_r),
        .cur_fill    (fill_r),
        .en          (En),
        .mode        (Mode),
        .din         (Din),
        .pin         (Pin),
        .next_stages (next_stages_s),
        .next_fill   (next_fill_s)
    );

    // State registers; reset clears everything without waiting for a clock
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_r <= '0;
            fill_r  <= '0;
        end else begin
            stage_r <= next_stages_s;
            fill_r  <= next_fill_s;
        end
    end

    assign Dout = stage_r[(DEPTH-1)*WIDTH +: WIDTH];
    assign Pout = stage_r;
    assign Fill = fill_r;
    assign Full = (fill_r == FILL_W'(DEPTH));

endmodule : param_shift_reg

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg: directed scenarios with literal
// expectations plus randomized operations against a word-level model.
module tb_param_shift_reg;

    localparam int W = 8;
    localparam int D = 4;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        En    = 1'b0;
    logic [2:0]  Mode  = 3'b000;
    logic [7:0]  Din   = 8'h00;
    logic [31:0] Pin   = 32'h0;
    logic [7:0]  Dout;
    logic [31:0] Pout;
    logic [2:0]  Fill;
    logic        Full;

    // Single-stage, 3-bit instance
    logic        en1   = 1'b0;
    logic [2:0]  mode1 = 3'b000;
    logic [2:0]  din1  = 3'd0;
    logic [2:0]  pin1  = 3'd0;
    logic [2:0]  dout1;
    logic [2:0]  pout1;
    logic [0:0]  fill1;
    logic        full1;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    // Word-level model: whole register as one 32-bit number, stage0 = low byte
    logic [31:0] m_state = 32'h0;
    int          m_fill  = 0;

    param_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .En(En), .Mode(Mode), .Din(Din), .Pin(Pin),
        .Dout(Dout), .Pout(Pout), .Fill(Fill), .Full(Full)
    );

    param_shift_reg #(.WIDTH(3), .DEPTH(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .En(en1), .Mode(mode1), .Din(din1), .Pin(pin1),
        .Dout(dout1), .Pout(pout1), .Fill(fill1), .Full(full1)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update on each edge from the rules of each operation
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_state <= 32'h0;
            m_fill  <= 0;
        end else if (En) begin
            case (Mode)
                3'd1: begin
                    m_state <= (m_state << 8) | {24'h0, Din};
                    m_fill  <= (m_fill < D) ? m_fill + 1 : D;
                end
                3'd2: begin
                    m_state <= (m_state >> 8) | ({24'h0, Din} << 24);
                    m_fill  <= (m_fill < D) ? m_fill + 1 : D;
                end
                3'd3: begin
                    m_state <= Pin;
                    m_fill  <= D;
                end
                3'd4: m_state <= (m_state << 8) | (m_state >> 24);
                3'd5: m_state <= (m_state >> 8) | (m_state << 24);
                3'd6: begin
                    m_state <= 32'h0;
                    m_fill  <= 0;
                end
                default: m_state <= m_state;
            endcase
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge CLK) begin
        if (cmp_on && RST_N) begin
            check("model_pout", {32'h0, Pout}, {32'h0, m_state});
            check("model_dout", {56'h0, Dout}, {56'h0, m_state[31:24]});
            check("model_fill", {61'h0, Fill}, 64'(m_fill));
            check("model_full", {63'h0, Full}, {63'h0, (m_fill == D)});
        end
    end

    task automatic do_op(input logic en, input logic [2:0] mode,
                         input logic [7:0] din, input logic [31:0] pin);
        @(negedge CLK);
        En = en; Mode = mode; Din = din; Pin = pin;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        En = 1'b0;
        #1 RST_N = 1'b0;
        #1 RST_N = 1'b1;
    endtask

    task automatic op1(input logic [2:0] mode, input logic [2:0] din);
        @(negedge CLK);
        en1 = 1'b1; mode1 = mode; din1 = din;
        @(posedge CLK);
        #1;
        en1 = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("reset_pout", {32'h0, Pout}, 64'h0);
        check("reset_fill", {61'h0, Fill}, 64'h0);
        check("reset_full", {63'h0, Full}, 64'h0);
        check("reset_dout1", {61'h0, dout1}, 64'h0);
        @(negedge CLK);
        RST_N  = 1'b1;
        cmp_on = 1'b1;

        // Shift in four bytes, then overflow
        do_op(1'b1, 3'd1, 8'h11, 32'h0);
        do_op(1'b1, 3'd1, 8'h22, 32'h0);
        do_op(1'b1, 3'd1, 8'h33, 32'h0);
        do_op(1'b1, 3'd1, 8'h44, 32'h0);
        check("shl4_pout", {32'h0, Pout}, 64'h11223344);
        check("shl4_dout", {56'h0, Dout}, 64'h11);
        check("shl4_fill", {61'h0, Fill}, 64'd4);
        check("shl4_full", {63'h0, Full}, 64'd1);
        do_op(1'b1, 3'd1, 8'h55, 32'h0);
        check("shl5_dout", {56'h0, Dout}, 64'h22);
        check("shl5_fill", {61'h0, Fill}, 64'd4);

        // Load then rotate both ways
        do_op(1'b1, 3'd3, 8'h00, 32'hA1B2C3D4);
        do_op(1'b1, 3'd4, 8'h00, 32'h0);
        check("rotl_pout", {32'h0, Pout}, 64'hB2C3D4A1);
        check("rotl_fill", {61'h0, Fill}, 64'd4);
        do_op(1'b1, 3'd5, 8'h00, 32'h0);
        check("rotr_pout", {32'h0, Pout}, 64'hA1B2C3D4);

        // Disabled clear does nothing; enabled clear empties
        for (int k = 0; k < 3; k++) do_op(1'b0, 3'd6, 8'hFF, 32'h0);
        check("hold_pout", {32'h0, Pout}, 64'hA1B2C3D4);
        check("hold_fill", {61'h0, Fill}, 64'd4);
        do_op(1'b1, 3'd6, 8'h00, 32'h0);
        check("clear_pout", {32'h0, Pout}, 64'h0);
        check("clear_fill", {61'h0, Fill}, 64'd0);
        check("clear_full", {63'h0, Full}, 64'd0);

        // Shift right after reset, then reserved code
        pulse_reset();
        do_op(1'b1, 3'd2, 8'h5A, 32'h0);
        check("shr_pout", {32'h0, Pout}, 64'h5A000000);
        check("shr_dout", {56'h0, Dout}, 64'h5A);
        check("shr_fill", {61'h0, Fill}, 64'd1);
        do_op(1'b1, 3'd7, 8'hC3, 32'h12345678);
        check("rsvd_pout", {32'h0, Pout}, 64'h5A000000);
        check("rsvd_fill", {61'h0, Fill}, 64'd1);

        // Asynchronous reset between edges
        do_op(1'b1, 3'd3, 8'h00, 32'hFFFFFFFF);
        check("loadff_pout", {32'h0, Pout}, 64'hFFFFFFFF);
        En = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        check("async_pout", {32'h0, Pout}, 64'h0);
        check("async_fill", {61'h0, Fill}, 64'd0);
        check("async_full", {63'h0, Full}, 64'd0);
        RST_N = 1'b1;
        do_op(1'b1, 3'd1, 8'h01, 32'h0);
        check("post_rst_pout", {32'h0, Pout}, 64'h00000001);
        check("post_rst_fill", {61'h0, Fill}, 64'd1);

        // Randomized operations checked against the model every cycle
        for (int k = 0; k < 400; k++) begin
            do_op(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), $urandom);
            if (k == 200) pulse_reset();
        end

        // Single-stage instance
        op1(3'd1, 3'd5);
        check("d1_shl_dout", {61'h0, dout1}, 64'd5);
        check("d1_shl_fill", {63'h0, fill1}, 64'd1);
        check("d1_shl_full", {63'h0, full1}, 64'd1);
        op1(3'd2, 3'd2);
        check("d1_shr_dout", {61'h0, dout1}, 64'd2);
        op1(3'd4, 3'd7);
        check("d1_rotl_dout", {61'h0, dout1}, 64'd2);
        op1(3'd5, 3'd7);
        check("d1_rotr_pout", {61'h0, pout1}, 64'd2);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_shift_reg

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of one stage.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the stage count; WIDTH>=1 and DEPTH>=1 are the legal ranges.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port En, input, 1 bit: operation enable; when 0 all state holds.
REQ-006 The block SHALL have port Mode, input, 3 bits: operation select, encoded per REQ-011.
REQ-007 The block SHALL have port Din, input, WIDTH bits: serial data in.
REQ-008 The block SHALL have port Pin, input, DEPTH*WIDTH bits: parallel load data; stage i is Pin[i*WIDTH +: WIDTH].
REQ-009 The block SHALL have these output ports:
- Dout, WIDTH bits: stage[DEPTH-1].
- Pout, DEPTH*WIDTH bits: all stages, packed as Pin.
- Fill, $clog2(DEPTH+1) bits: count of stages holding shifted-in or loaded data.
- Full, 1 bit: Fill==DEPTH.

Function
REQ-010 The block SHALL keep state in DEPTH registered stages; the next state SHALL be computed combinationally from current state and inputs and registered on the CLK rising edge (1-cycle latency, input to Pout).
REQ-011 With En=1, Mode SHALL select one operation:
- 000 HOLD.
- 001 SHL: stage[0]<=Din, stage[i]<=stage[i-1].
- 010 SHR: stage[DEPTH-1]<=Din, stage[i]<=stage[i+1].
- 011 LOAD: stage[i]<=Pin slice i.
- 100 ROTL: stage[0]<=stage[DEPTH-1], others as SHL.
- 101 ROTR: stage[DEPTH-1]<=stage[0], others as SHR.
- 110 CLEAR: all stages<=0.
- 111 reserved: behaves as HOLD.
REQ-012 With En=0, stages and Fill SHALL hold regardless of Mode, Din and Pin.
REQ-013 Fill SHALL update as follows:
- SHL/SHR: +1, saturating at DEPTH.
- LOAD: set to DEPTH.
- CLEAR: set to 0.
- HOLD/ROTL/ROTR/reserved: unchanged.
REQ-014 Full SHALL be combinational from registered Fill; Dout and Pout SHALL be driven directly from registers, with no combinational path from inputs.
REQ-015 At DEPTH=1: SHL and SHR SHALL both load Din into stage[0]; ROTL and ROTR SHALL leave state unchanged.
REQ-016 SHL/SHR while Full=1 SHALL still shift, discarding the outgoing stage, and Fill SHALL stay DEPTH.

Reset
REQ-017 RST_N=0 SHALL immediately clear all stages and Fill to 0, independent of CLK; Dout=0, Pout=0, Fill=0, Full=0 (Full=1 never at reset).
REQ-018 Reset asserted mid-operation SHALL abandon that cycle's update; the first edge after RST_N deasserts SHALL perform a normal operation from the cleared state.

Configuration
REQ-019 With macro PARAM_SHIFT_REG_ASSERT_EN defined, the block SHALL compile in these immediate assertions in the next-state logic:
- En=0 implies next state equals current state.
- En=1 and Mode=SHL implies next stage[0]==Din.
- En=1 and Mode=LOAD implies next Pout==Pin.
- Fill<=DEPTH at all times.
REQ-020 Without PARAM_SHIFT_REG_ASSERT_EN, no assertions SHALL be compiled in, and functional behaviour SHALL be identical.

Structure
REQ-021 Package param_shift_reg_pkg SHALL hold the Mode encoding typedef (enum of the eight codes) and the mode constants.
REQ-022 The combinational next-state logic (stages and Fill) SHALL be sub-module param_shift_reg_next; the top holds the registers, the reset and the outputs.

Verification (WIDTH=8, DEPTH=4)
REQ-023 Bench SHALL cover reset, then SHL of Din=0x11,0x22,0x33,0x44 -> Pout=0x11223344 (stage3..0) with Dout=0x11, Fill=4, Full=1; a 5th SHL of 0x55 -> Dout=0x22, Fill=4.
REQ-024 Bench SHALL cover LOAD Pin=0xA1B2C3D4 then ROTL -> Pout=0xB2C3D4A1, Fill=4; then ROTR -> Pout=0xA1B2C3D4.
REQ-025 Bench SHALL cover En=0 with Mode=CLEAR, Din=0xFF for 3 cycles -> Pout and Fill unchanged; then En=1 CLEAR -> Pout=0, Fill=0, Full=0.
REQ-026 Bench SHALL cover SHR of Din=0x5A after reset -> stage3=0x5A, Dout=0x5A, Fill=1; and Mode=111 -> state unchanged.
REQ-027 Bench SHALL cover RST_N pulsed low between clock edges after LOAD 0xFFFFFFFF -> Pout=0 and Fill=0 immediately, without a clock edge; the next SHL of Din=0x01 -> Pout=0x00000001.
REQ-028 Bench SHALL cover DEPTH=1, WIDTH=3: SHL Din=5 -> Dout=5; then SHR Din=2 -> Dout=2; then ROTL -> Dout=2; all with PARAM_SHIFT_REG_ASSERT_EN defined, and no assertion fires.
